// File: rtl/melody_sequencer.sv
// Song ROM stepper: walks a 16-entry note table at a fixed tempo and drives the buzzer period,
// with a muted articulation gap at the end of each note and start/stop/pause/loop control.
module melody_sequencer #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int GAP_TICKS = 1,
  parameter int SONG_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop_en,
  output logic [19:0] note_div,
  output logic [3:0]  note_idx,
  output logic        playing,
  output logic        done
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, PLAY, GAP, PAUSED, DONE} state_t;
  typedef struct packed { logic [3:0] code; logic [3:0] dur; } entry_t;

  function automatic entry_t rom(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:   rom = entry_t'(8'h12);
      4'd2, 4'd3:   rom = entry_t'(8'h52);
      4'd4, 4'd5:   rom = entry_t'(8'h62);
      4'd6:         rom = entry_t'(8'h54);
      4'd7, 4'd8:   rom = entry_t'(8'h42);
      4'd9, 4'd10:  rom = entry_t'(8'h32);
      4'd11, 4'd12: rom = entry_t'(8'h22);
      4'd13:        rom = entry_t'(8'h14);
      4'd14:        rom = entry_t'(8'h02);
      default:      rom = entry_t'(8'h00);
    endcase
  endfunction

  function automatic logic [19:0] div_tbl(input logic [3:0] code);
    case (code)
      4'd1:    div_tbl = 20'd152890;
      4'd2:    div_tbl = 20'd136208;
      4'd3:    div_tbl = 20'd121349;
      4'd4:    div_tbl = 20'd114540;
      4'd5:    div_tbl = 20'd102042;
      4'd6:    div_tbl = 20'd90909;
      4'd7:    div_tbl = 20'd80991;
      4'd8:    div_tbl = 20'd76445;
      4'd9:    div_tbl = 20'd68104;
      4'd10:   div_tbl = 20'd60675;
      4'd11:   div_tbl = 20'd57270;
      4'd12:   div_tbl = 20'd51021;
      4'd13:   div_tbl = 20'd45455;
      4'd14:   div_tbl = 20'd40495;
      4'd15:   div_tbl = 20'd38223;
      default: div_tbl = 20'd0;
    endcase
  endfunction

  state_t        state, saved, eff;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    remaining, rem_dec, next_idx, ld_idx;
  logic          tick, last, adv_end, ld_ok, run, advance;
  entry_t        cur, nxt_e, ld;

  // A PAUSED cycle with pause already released behaves as the saved state, so only
  // cycles with pause high are lost from the note timing.
  always_comb begin
    eff      = (state == PAUSED && !pause) ? saved : state;
    run      = (eff == PLAY || eff == GAP) && !pause;
    tick     = (tick_cnt == CW'(TICK_DIV - 1));
    rem_dec  = remaining - 4'd1;
    cur      = rom(note_idx);
    last     = (note_idx == 4'(SONG_LEN - 1));
    next_idx = last ? 4'd0 : note_idx + 4'd1;
    nxt_e    = rom(next_idx);
    adv_end  = last || (nxt_e.dur == 4'd0);
    ld_idx   = (start || adv_end) ? 4'd0 : next_idx;
    ld       = rom(ld_idx);
    ld_ok    = (ld.dur != 4'd0) && (start || !adv_end || loop_en);
    advance  = start || (run && tick && rem_dec == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      saved     <= IDLE;
      tick_cnt  <= '0;
      remaining <= '0;
      note_div  <= '0;
      note_idx  <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      saved     <= IDLE;
      tick_cnt  <= '0;
      remaining <= '0;
      note_div  <= '0;
      note_idx  <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (advance) begin
      tick_cnt <= '0;
      if (ld_ok) begin
        state     <= PLAY;
        note_idx  <= ld_idx;
        remaining <= ld.dur;
        note_div  <= div_tbl(ld.code);
        playing   <= 1'b1;
        done      <= 1'b0;
      end else begin
        state     <= DONE;
        remaining <= '0;
        note_div  <= '0;
        playing   <= 1'b0;
        done      <= 1'b1;
      end
    end else if (pause && (state == PLAY || state == GAP)) begin
      saved    <= state;
      state    <= PAUSED;
      note_div <= '0;
    end else if (run) begin
      state    <= eff;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      note_div <= (eff == PLAY) ? div_tbl(cur.code) : '0;
      if (tick) begin
        remaining <= rem_dec;
        if (eff == PLAY && rem_dec == 4'(GAP_TICKS) && cur.dur > 4'(GAP_TICKS)) begin
          state    <= GAP;
          note_div <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-cycle tempo tick and the default song.
module tb_melody_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, pause, loop_en;
  logic [19:0] note_div;
  logic [3:0]  note_idx;
  logic        playing, done;
  int          total = 0;
  int          bad = 0;

  localparam int C4 = 152890, D4 = 136208, E4 = 121349, F4 = 114540, G4 = 102042, A4 = 90909;

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .SONG_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .note_div(note_div), .note_idx(note_idx), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int div, input int idx, input int ply, input int dn);
    chk({tag, ".note_div"}, 32'(note_div), div);
    chk({tag, ".note_idx"}, 32'(note_idx), idx);
    chk({tag, ".playing"}, 32'(playing), ply);
    chk({tag, ".done"}, 32'(done), dn);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    adv(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    adv(2);
    rst_n = 1'b1;
    expect_out("reset", 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      adv(1);
      expect_out("idle", 0, 0, 0, 0);
    end

    // Play from the top; edge offsets below are relative to the start edge.
    pulse_start();
    expect_out("e0_load", C4, 0, 1, 0);
    adv(3);
    expect_out("e0_sound", C4, 0, 1, 0);
    adv(1);
    expect_out("e0_gap", 0, 0, 1, 0);
    adv(4);
    expect_out("e1_load", C4, 1, 1, 0);
    adv(8);
    expect_out("e2_load", G4, 2, 1, 0);
    adv(24);
    expect_out("e5_load", A4, 5, 1, 0);
    adv(8);
    expect_out("e6_load", G4, 6, 1, 0);

    // Pause after one tick of entry 6; 12 more active cycles must follow the release.
    adv(4);
    pause = 1'b1;
    adv(1);
    expect_out("pause_mute", 0, 6, 1, 0);
    adv(19);
    expect_out("pause_hold", 0, 6, 1, 0);
    pause = 1'b0;
    adv(1);
    expect_out("resume", G4, 6, 1, 0);
    adv(6);
    expect_out("e6_sound_end", G4, 6, 1, 0);
    adv(1);
    expect_out("e6_gap", 0, 6, 1, 0);
    adv(3);
    expect_out("e6_gap_end", 0, 6, 1, 0);
    adv(1);
    expect_out("e7_load", F4, 7, 1, 0);
    adv(16);
    expect_out("e9_load", E4, 9, 1, 0);
    adv(16);
    expect_out("e11_load", D4, 11, 1, 0);
    adv(16);
    expect_out("e13_load", C4, 13, 1, 0);
    adv(16);
    expect_out("e14_rest", 0, 14, 1, 0);
    adv(7);
    expect_out("e14_last", 0, 14, 1, 0);
    adv(1);
    expect_out("song_done", 0, 14, 0, 1);
    adv(10);
    expect_out("done_hold", 0, 14, 0, 1);

    // Looping run from DONE.
    loop_en = 1'b1;
    pulse_start();
    expect_out("loop_start", C4, 0, 1, 0);
    adv(135);
    expect_out("loop_pre_wrap", 0, 14, 1, 0);
    adv(1);
    expect_out("loop_wrap", C4, 0, 1, 0);

    // start+stop together, restart, stop alone.
    adv(2);
    start = 1'b1; stop = 1'b1;
    adv(1);
    start = 1'b0; stop = 1'b0;
    expect_out("start_stop", 0, 0, 0, 0);
    adv(5);
    expect_out("start_stop_idle", 0, 0, 0, 0);
    pulse_start();
    expect_out("restart", C4, 0, 1, 0);
    adv(16);
    expect_out("restart_e2", G4, 2, 1, 0);
    pulse_start();
    expect_out("restart_mid", C4, 0, 1, 0);
    adv(3);
    stop = 1'b1;
    adv(1);
    stop = 1'b0;
    expect_out("stop", 0, 0, 0, 0);

    // Asynchronous reset in the middle of entry 2's gap.
    pulse_start();
    adv(20);
    expect_out("e2_gap", 0, 2, 1, 0);
    rst_n = 1'b0;
    #2;
    expect_out("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out("rst_release", 0, 0, 0, 0);
    pulse_start();
    expect_out("post_rst_load", C4, 0, 1, 0);
    adv(4);
    expect_out("post_rst_gap", 0, 0, 1, 0);
    adv(4);
    expect_out("post_rst_e1", C4, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
